// File: rtl/spi_slave_rx_tx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_tx
//
// SPI slave supporting all four modes (cpol/cpha chosen at run time). It
// receives one byte per 8 sample edges from the master and transmits one
// byte from a single-entry TX buffer. The SPI pins are asynchronous to clk
// and are resynchronised before any edge detection.
//
// Optional feature: define SPI_SLAVE_UNDERRUN_EN to build the sticky
// underrun flag. Without it, underrun is tied low.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   cpol      clock polarity (sck idle level)
//   cpha      clock phase (0: sample leading edge, 1: sample trailing edge)
//   sck       SPI clock from master (asynchronous)
//   mosi      serial data from master
//   ss        slave select, active-low
//   miso      serial data to master
//   tx_data   byte to transmit
//   tx_load   one-cycle strobe writing tx_data into the TX buffer
//   tx_ready  TX buffer empty
//   rx_data   last complete received byte
//   rx_valid  one-cycle pulse when rx_data updates
//   busy      ss synchronised low
//   abort     one-cycle pulse when ss rises mid-byte
//   underrun  sticky: a byte started with an empty TX buffer
// ---------------------------------------------------------------------------
module spi_slave_rx_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       abort,
  output logic       underrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    SHIFT    = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sckSync_q;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic [SYNC_STAGES-1:0] ssSync_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   sckPrev_q;
  logic                   ssPrev_q;
  logic                   armed_q;

  state_t     state_q, state_d;
  logic [7:0] txShift_q, txShift_d;
  logic [7:0] rxShift_q, rxShift_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] txBuf_q, txBuf_d;
  logic       txFull_q, txFull_d;
  logic [7:0] rxData_q, rxData_d;
  logic       rxValid_q, rxValid_d;
  logic       abort_q, abort_d;

  logic       sckS, mosiS, ssS;
  logic       leadEdge, trailEdge, sampleEdge, shiftEdge;
  logic       ssFall;
  logic [7:0] loadByte;

  assign sckS  = sckSync_q[SYNC_STAGES-1];
  assign mosiS = mosiSync_q[SYNC_STAGES-1];
  assign ssS   = ssSync_q[SYNC_STAGES-1];

  assign leadEdge   = (sckPrev_q == cpol) && (sckS != cpol);
  assign trailEdge  = (sckPrev_q != cpol) && (sckS == cpol);
  assign sampleEdge = cpha ? trailEdge : leadEdge;
  assign shiftEdge  = cpha ? leadEdge  : trailEdge;

  // The ss synchroniser is preset high, so a pin held low through reset
  // would look like a falling edge once it propagates. armed_q only sets
  // after the chain has flushed its preset and a real high level was seen,
  // so a transfer interrupted by reset is never resumed.
  assign ssFall = armed_q && ssPrev_q && !ssS;

  assign loadByte = txFull_q ? txBuf_q : 8'h00;

  // Synchronisers, edge-detect history and the post-reset arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sckSync_q  <= '0;
      mosiSync_q <= '0;
      ssSync_q   <= '1;
      settle_q   <= '0;
      sckPrev_q  <= 1'b0;
      ssPrev_q   <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], sck};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
      ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], ss};
      settle_q   <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      sckPrev_q  <= sckS;
      ssPrev_q   <= ssS;
      armed_q    <= armed_q || (settle_q[SYNC_STAGES-1] && ssS);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      txShift_q <= 8'h00;
      rxShift_q <= 8'h00;
      bitCnt_q  <= 3'd7;
      txBuf_q   <= 8'h00;
      txFull_q  <= 1'b0;
      rxData_q  <= 8'h00;
      rxValid_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      txShift_q <= txShift_d;
      rxShift_q <= rxShift_d;
      bitCnt_q  <= bitCnt_d;
      txBuf_q   <= txBuf_d;
      txFull_q  <= txFull_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state logic. bitCnt_q == 7 means no sample edge has happened yet in
  // the current byte; shift edges are ignored until then. That holds bit 7
  // on miso through the first shift edge in cpha=1, and in cpha=0 it swallows
  // the trailing edge left over from the previous byte of a back-to-back
  // burst. The same test separates a real mid-byte ss rise (abort) from the
  // ss rise that follows the final byte, which lands in the freshly started
  // next byte before any sample.
  always_comb begin
    state_d   = state_q;
    txShift_d = txShift_q;
    rxShift_d = rxShift_q;
    bitCnt_d  = bitCnt_q;
    txBuf_d   = txBuf_q;
    txFull_d  = txFull_q;
    rxData_d  = rxData_q;
    rxValid_d = 1'b0;
    abort_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ssFall) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        txShift_d = loadByte;
        txFull_d  = 1'b0;
        bitCnt_d  = 3'd7;
        rxShift_d = 8'h00;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (ssS) begin
          state_d = IDLE;
          abort_d = (bitCnt_q != 3'd7);
        end else if (sampleEdge) begin
          rxShift_d = {rxShift_q[6:0], mosiS};
          if (bitCnt_q == 3'd0) begin
            state_d = COMPLETE;
          end else begin
            bitCnt_d = bitCnt_q - 3'd1;
          end
        end else if (shiftEdge && (bitCnt_q != 3'd7)) begin
          txShift_d = {txShift_q[6:0], 1'b0};
        end
      end
      COMPLETE: begin
        rxData_d  = rxShift_q;
        rxValid_d = 1'b1;
        state_d   = ssS ? IDLE : LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A load in the LOAD cycle lands in the buffer for the following byte.
    if (tx_load) begin
      txBuf_d  = tx_data;
      txFull_d = 1'b1;
    end
  end

  // In LOAD the shift register is not yet filled, so bit 7 comes straight
  // from the buffer to present the MSB from the LOAD cycle onward.
  always_comb begin
    miso = 1'b0;
    case (state_q)
      IDLE:    miso = 1'b0;
      LOAD:    miso = loadByte[7];
      default: miso = txShift_q[7];
    endcase
  end

  assign tx_ready = !txFull_q;
  assign rx_data  = rxData_q;
  assign rx_valid = rxValid_q;
  assign busy     = !ssS;
  assign abort    = abort_q;

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;

  // Set when a byte starts without buffered data; a new load clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else if ((state_q == LOAD) && !txFull_q) begin
      underrun_q <= 1'b1;
    end else if (tx_load) begin
      underrun_q <= 1'b0;
    end
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_rx_tx
//
// Bench for spi_slave_rx_tx. A behavioural SPI master drives the pins; a
// byte-level reference model (single-entry TX buffer, last received byte)
// predicts what the master should see on miso and what rx_data should hold.
// Directed scenarios are followed by a randomised loop over all four modes.
// ---------------------------------------------------------------------------
module tb_spi_slave_rx_tx;

  localparam int HALF = 6;

`ifdef SPI_SLAVE_UNDERRUN_EN
  localparam logic UR_EN = 1'b1;
`else
  localparam logic UR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpol, cpha;
  logic       sck, mosi, ss;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       abort;
  logic       underrun;

  int errorCount   = 0;
  int checkCount   = 0;
  int rxValidCount = 0;
  int abortCount   = 0;

  // Reference model state: one-entry TX buffer and last complete RX byte.
  logic       modelFull;
  logic [7:0] modelBuf;
  logic [7:0] modelRx;

  spi_slave_rx_tx #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpol     (cpol),
    .cpha     (cpha),
    .sck      (sck),
    .mosi     (mosi),
    .ss       (ss),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .abort    (abort),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (rx_valid) rxValidCount++;
    if (abort)    abortCount++;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadTx(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    modelFull = 1'b1;
    modelBuf  = b;
  endtask

  // The byte the master should receive next: buffered data, else zero.
  function automatic logic [7:0] modelTake();
    logic [7:0] r;
    r = modelFull ? modelBuf : 8'h00;
    modelFull = 1'b0;
    return r;
  endfunction

  task automatic setMode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sck  = pol;
    waitCycles(4 * HALF);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    modelFull = 1'b0;
    modelRx   = 8'h00;
    waitCycles(5);
  endtask

  // Behavioural SPI master for one byte. nSamples < 8 raises ss early;
  // resetAt >= 0 pulses rst_n at the start of that bit and ends the frame.
  task automatic applyStimulus(input logic [7:0] mosiByte, input int nSamples,
                               input logic doFall, input logic doRise,
                               input int resetAt, output logic [7:0] misoByte);
    logic [7:0] acc;
    acc = 8'h00;
    if (doFall) begin
      sck  = cpol;
      mosi = mosiByte[7];
      waitCycles(HALF);
      ss = 1'b0;
      waitCycles(2 * HALF);
    end
    for (int i = 0; i < nSamples; i++) begin
      if (i == resetAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_miso",     {31'd0, miso},     32'd0);
        checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("rst_rx_data",  {24'd0, rx_data},  32'd0);
        checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_busy",     {31'd0, busy},     32'd0);
        checkOutput("rst_abort",    {31'd0, abort},    32'd0);
        checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
        waitCycles(3);
        rst_n = 1'b1;
        modelFull = 1'b0;
        modelRx   = 8'h00;
        // Keep clocking with ss still low; these edges must not start a byte.
        for (int k = 0; k < 10; k++) begin
          waitCycles(HALF);
          sck = ~sck;
        end
        break;
      end
      if (!cpha) begin
        mosi = mosiByte[7-i];
        waitCycles(HALF);
        sck = ~cpol;
        acc[7-i] = miso;
        waitCycles(HALF);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = mosiByte[7-i];
        waitCycles(HALF);
        acc[7-i] = miso;
        sck = cpol;
        waitCycles(HALF);
      end
    end
    if (doRise || (resetAt >= 0)) begin
      waitCycles(HALF);
      sck = cpol;
      ss  = 1'b1;
      waitCycles(4 * HALF);
    end
    misoByte = acc;
  endtask

  initial begin
    logic [7:0] m1, m2, txb, mb, expTx;
    int         rv0, ab0;
    logic       pol, pha, doLoad, gotReady;

    rst_n   = 1'b0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    sck     = 1'b0;
    mosi    = 1'b0;
    ss      = 1'b1;
    tx_data = 8'h00;
    tx_load = 1'b0;
    modelFull = 1'b0;
    modelBuf  = 8'h00;
    modelRx   = 8'h00;

    waitCycles(3);
    checkOutput("reset_miso",     {31'd0, miso},     32'd0);
    checkOutput("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset_rx_data",  {24'd0, rx_data},  32'd0);
    checkOutput("reset_busy",     {31'd0, busy},     32'd0);
    checkOutput("reset_underrun", {31'd0, underrun}, 32'd0);
    rst_n = 1'b1;
    waitCycles(5);

    // Mode 0 single byte.
    setMode(1'b0, 1'b0);
    loadTx(8'hA5);
    checkOutput("m0_tx_ready_low", {31'd0, tx_ready}, 32'd0);
    rv0 = rxValidCount;
    expTx = modelTake();
    applyStimulus(8'h3C, 8, 1'b1, 1'b1, -1, m1);
    modelRx = 8'h3C;
    checkOutput("m0_miso",     {24'd0, m1},       {24'd0, expTx});
    checkOutput("m0_rx_data",  {24'd0, rx_data},  {24'd0, modelRx});
    checkOutput("m0_rx_valid", rxValidCount - rv0, 32'd1);
    checkOutput("m0_tx_ready", {31'd0, tx_ready}, 32'd1);

    // Mode 3 single byte.
    setMode(1'b1, 1'b1);
    loadTx(8'h81);
    expTx = modelTake();
    applyStimulus(8'hF0, 8, 1'b1, 1'b1, -1, m1);
    modelRx = 8'hF0;
    checkOutput("m3_miso",    {24'd0, m1},      {24'd0, expTx});
    checkOutput("m3_rx_data", {24'd0, rx_data}, {24'd0, modelRx});

    // Back-to-back bytes with ss held low; second byte loaded mid-transfer.
    setMode(1'b0, 1'b0);
    loadTx(8'h11);
    rv0 = rxValidCount;
    gotReady = 1'b0;
    fork
      begin
        applyStimulus(8'hAB, 8, 1'b1, 1'b0, -1, m1);
        applyStimulus(8'hCD, 8, 1'b0, 1'b1, -1, m2);
      end
      begin
        for (int k = 0; k < 2000; k++) begin
          @(negedge clk);
          if (tx_ready) begin
            gotReady = 1'b1;
            break;
          end
        end
        if (gotReady) loadTx(8'h22);
      end
    join
    modelFull = 1'b0;
    modelRx   = 8'hCD;
    checkOutput("b2b_ready_seen", {31'd0, gotReady}, 32'd1);
    checkOutput("b2b_miso0",      {24'd0, m1},       32'h11);
    checkOutput("b2b_miso1",      {24'd0, m2},       32'h22);
    checkOutput("b2b_rx_data",    {24'd0, rx_data},  {24'd0, modelRx});
    checkOutput("b2b_rx_valid",   rxValidCount - rv0, 32'd2);

    // ss raised after four sample edges, then a full byte.
    rv0 = rxValidCount;
    ab0 = abortCount;
    applyStimulus(8'h96, 4, 1'b1, 1'b1, -1, m1);
    checkOutput("abort_pulse",    abortCount - ab0,   32'd1);
    checkOutput("abort_no_valid", rxValidCount - rv0, 32'd0);
    checkOutput("abort_rx_hold",  {24'd0, rx_data},   {24'd0, modelRx});
    loadTx(8'h3D);
    expTx = modelTake();
    applyStimulus(8'h5A, 8, 1'b1, 1'b1, -1, m1);
    modelRx = 8'h5A;
    checkOutput("after_abort_rx",   {24'd0, rx_data}, {24'd0, modelRx});
    checkOutput("after_abort_miso", {24'd0, m1},      {24'd0, expTx});

    // Byte started with an empty TX buffer.
    resetDut();
    expTx = modelTake();
    applyStimulus(8'h24, 8, 1'b1, 1'b1, -1, m1);
    checkOutput("underrun_miso", {24'd0, m1},       {24'd0, expTx});
    checkOutput("underrun_set",  {31'd0, underrun}, {31'd0, UR_EN});
    loadTx(8'h77);
    checkOutput("underrun_clr",  {31'd0, underrun}, 32'd0);
    expTx = modelTake();
    applyStimulus(8'h42, 8, 1'b1, 1'b1, -1, m1);
    checkOutput("underrun_next_miso", {24'd0, m1}, {24'd0, expTx});

    // Reset during bit 3 of a transfer, then a fresh transfer.
    setMode(1'b0, 1'b1);
    loadTx(8'h6E);
    rv0 = rxValidCount;
    applyStimulus(8'h99, 8, 1'b1, 1'b1, 3, m1);
    checkOutput("rst_mid_no_valid", rxValidCount - rv0, 32'd0);
    checkOutput("rst_mid_rx_data",  {24'd0, rx_data},   32'd0);
    loadTx(8'hE1);
    rv0 = rxValidCount;
    expTx = modelTake();
    applyStimulus(8'hC3, 8, 1'b1, 1'b1, -1, m1);
    modelRx = 8'hC3;
    checkOutput("post_rst_rx",    {24'd0, rx_data},   {24'd0, modelRx});
    checkOutput("post_rst_valid", rxValidCount - rv0, 32'd1);
    checkOutput("post_rst_miso",  {24'd0, m1},        {24'd0, expTx});

    // Randomised bytes in random modes, with and without a preload.
    for (int n = 0; n < 16; n++) begin
      pol    = 1'($urandom_range(0, 1));
      pha    = 1'($urandom_range(0, 1));
      doLoad = ($urandom_range(0, 3) != 0);
      txb    = 8'($urandom);
      mb     = 8'($urandom);
      setMode(pol, pha);
      if (doLoad) loadTx(txb);
      rv0 = rxValidCount;
      expTx = modelTake();
      applyStimulus(mb, 8, 1'b1, 1'b1, -1, m1);
      modelRx = mb;
      checkOutput("rand_miso",  {24'd0, m1},       {24'd0, expTx});
      checkOutput("rand_rx",    {24'd0, rx_data},  {24'd0, modelRx});
      checkOutput("rand_valid", rxValidCount - rv0, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
